// File: rtl/perip_bridge.sv
// perip_bridge: zero-wait-state bridge from the CPU data port to a word-indexed
// data RAM and a small set of memory-mapped peripherals (switches, LEDs, a
// prescaled free-running counter and a seven-segment display register).
// Reads are purely combinational from perip_addr; every write lands on the
// rising cpu_clk edge of the cycle in which perip_wen is high.

module perip_bridge #(
   parameter int unsigned DRAM_WORDS = 4096,   // data RAM depth in 32-bit words, power of two
   parameter int unsigned PRESCALE   = 50000   // clock cycles per counter tick
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   input  logic [31:0] perip_addr,
   input  logic        perip_wen,
   input  logic [1:0]  perip_mask,
   input  logic [31:0] perip_wdata,
   output logic [31:0] perip_rdata,
   input  logic [23:0] sw,
   output logic [23:0] led,
   output logic [31:0] seg_data
);

   // ------------------------------------------------------------------
   // Address map
   // ------------------------------------------------------------------
   localparam logic [31:0] DRAM_BASE  = 32'h8010_0000;
   localparam logic [31:0] DRAM_BYTES = 32'(4 * DRAM_WORDS);
   localparam int unsigned DRAM_AW    = (DRAM_WORDS > 1) ? $clog2(DRAM_WORDS) : 1;

   localparam logic [31:0] SW_ADDR    = 32'h8020_0000;
   localparam logic [31:0] LED_ADDR   = 32'h8020_0040;
   localparam logic [31:0] CNT_ADDR   = 32'h8020_0050;
   localparam logic [31:0] SEG_ADDR   = 32'h8020_0060;

   // Access sizes carried on perip_mask (2'b11 is reserved)
   localparam logic [1:0]  MASK_BYTE  = 2'b00;
   localparam logic [1:0]  MASK_HALF  = 2'b01;
   localparam logic [1:0]  MASK_WORD  = 2'b10;

   // Counter control words; any other value written to CNT is ignored
   localparam logic [31:0] CNT_START  = 32'h8000_0000;
   localparam logic [31:0] CNT_STOP   = 32'hFFFF_FFFF;

   // Prescaler runs 0..PRESCALE-1
   localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   // Counter state machine encoding
   localparam logic [0:0]  ST_IDLE    = 1'b0;
   localparam logic [0:0]  ST_RUN     = 1'b1;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic [31:0]        dram_off;
   logic [DRAM_AW-1:0] dram_idx;
   logic               is_dram;
   logic               is_sw;
   logic               is_led;
   logic               is_cnt;
   logic               is_seg;

   // An address below the base wraps to a huge offset, so one unsigned
   // compare covers both ends of the RAM window.
   assign dram_off = perip_addr - DRAM_BASE;
   assign is_dram  = (dram_off < DRAM_BYTES);
   assign dram_idx = dram_off[DRAM_AW+1:2];

   assign is_sw    = (perip_addr == SW_ADDR);
   assign is_led   = (perip_addr == LED_ADDR);
   assign is_cnt   = (perip_addr == CNT_ADDR);
   assign is_seg   = (perip_addr == SEG_ADDR);

   // ------------------------------------------------------------------
   // Data RAM
   // ------------------------------------------------------------------
   logic [31:0] dram [DRAM_WORDS];
   logic [3:0]  dram_be;      // per-byte-lane write enables
   logic [31:0] dram_wdata;   // store data replicated onto every lane

   // Steer the right-aligned store data onto its byte lanes; misaligned or
   // reserved-size stores end up with no lane enabled and so are dropped.
   always_comb begin
      // NOTE: every output gets a default before the case so no path can
      // leave it unassigned, which would otherwise infer a latch.
      dram_be    = 4'b0000;
      dram_wdata = perip_wdata;
      case (perip_mask)
         MASK_BYTE: begin
            dram_wdata = {4{perip_wdata[7:0]}};
            dram_be    = 4'b0001 << perip_addr[1:0];
         end
         MASK_HALF: begin
            dram_wdata = {2{perip_wdata[15:0]}};
            if (!perip_addr[0]) begin
               dram_be = perip_addr[1] ? 4'b1100 : 4'b0011;
            end
         end
         MASK_WORD: begin
            if (perip_addr[1:0] == 2'b00) begin
               dram_be = 4'b1111;
            end
         end
         default: dram_be = 4'b0000;
      endcase
      if (!(perip_wen && is_dram)) begin
         dram_be = 4'b0000;
      end
   end

   // Byte-lane writes into the RAM; a same-cycle read still sees the old word.
   // NOTE: the RAM has no reset branch on purpose: its contents are undefined
   // at power-up, survive cpu_rst, and this lets it map onto block RAM.
   always_ff @(posedge cpu_clk) begin
      for (int i = 0; i < 4; i++) begin
         if (dram_be[i]) begin
            dram[dram_idx][8*i +: 8] <= dram_wdata[8*i +: 8];
         end
      end
   end

   // ------------------------------------------------------------------
   // Switch synchronizer
   // ------------------------------------------------------------------
   logic [23:0] sw_sync1;
   logic [23:0] sw_sync2;

   // Two-flop synchronizer for the asynchronous switch inputs.
   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge value; blocking = here would collapse the two stages.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         sw_sync1 <= '0;
         sw_sync2 <= '0;
      end else begin
         sw_sync1 <= sw;
         sw_sync2 <= sw_sync1;
      end
   end

   // ------------------------------------------------------------------
   // LED and seven-segment registers
   // ------------------------------------------------------------------
   logic led_we;
   logic seg_we;

   // Peripheral registers take the whole store word regardless of access size.
   assign led_we = perip_wen && is_led;
   assign seg_we = perip_wen && is_seg;

   // LED register load.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         led <= '0;
      end else if (led_we) begin
         led <= perip_wdata[23:0];
      end
   end

   // Seven-segment register load.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         seg_data <= '0;
      end else if (seg_we) begin
         seg_data <= perip_wdata;
      end
   end

   // ------------------------------------------------------------------
   // Prescaled counter
   // ------------------------------------------------------------------
   logic [0:0]      cnt_state;
   logic [0:0]      cnt_state_next;
   logic [31:0]     count;
   logic [PS_W-1:0] prescaler;
   logic            cnt_start;
   logic            cnt_stop;
   logic            cnt_tick;

   assign cnt_start = perip_wen && is_cnt && (perip_wdata == CNT_START);
   assign cnt_stop  = perip_wen && is_cnt && (perip_wdata == CNT_STOP);
   assign cnt_tick  = (prescaler == PS_LAST);

   // Next state: a start write always lands in RUN, a stop write in IDLE,
   // anything else keeps the current state.
   always_comb begin
      cnt_state_next = cnt_state;
      if (cnt_start) begin
         cnt_state_next = ST_RUN;
      end else if (cnt_stop) begin
         cnt_state_next = ST_IDLE;
      end
   end

   // State register plus count/prescaler datapath; a control write wins over
   // the count update scheduled for the same edge.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         cnt_state <= ST_IDLE;
         count     <= '0;
         prescaler <= '0;
      end else begin
         cnt_state <= cnt_state_next;
         if (cnt_start) begin
            count     <= '0;
            prescaler <= '0;
         end else if (cnt_stop) begin
            count     <= count;
            prescaler <= prescaler;
         end else if (cnt_state == ST_RUN) begin
            if (cnt_tick) begin
               prescaler <= '0;
               count     <= count + 32'd1;
            end else begin
               prescaler <= prescaler + PS_W'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Read data mux
   // ------------------------------------------------------------------

   // Combinational read of the addressed location; unmapped addresses read 0.
   always_comb begin
      perip_rdata = 32'h0;
      if (is_dram) begin
         perip_rdata = dram[dram_idx];
      end else if (is_sw) begin
         perip_rdata = {8'h0, sw_sync2};
      end else if (is_led) begin
         perip_rdata = {8'h0, led};
      end else if (is_cnt) begin
         perip_rdata = count;
      end else if (is_seg) begin
         perip_rdata = seg_data;
      end
   end

endmodule

// File: tb/tb_perip_bridge.sv
// tb_perip_bridge: randomized scoreboard bench for perip_bridge. A driver
// issues one bus cycle per clock and pushes the expected read data, LED and
// SEG values into a queue; a monitor on the falling edge pops and compares.
// Expectations come from a byte-addressed memory model and a cycle-count
// model of the counter, not from the DUT.

module tb_perip_bridge;

   localparam int unsigned DRAM_WORDS = 64;
   localparam int unsigned PRESCALE   = 4;
   localparam int unsigned DRAM_BYTES = 4 * DRAM_WORDS;

   localparam logic [31:0] DB     = 32'h8010_0000;
   localparam logic [31:0] SW_A   = 32'h8020_0000;
   localparam logic [31:0] LED_A  = 32'h8020_0040;
   localparam logic [31:0] CNT_A  = 32'h8020_0050;
   localparam logic [31:0] SEG_A  = 32'h8020_0060;
   localparam logic [31:0] UNMAP  = 32'h8030_0000;

   localparam logic [1:0]  K_RDATA = 2'd0;
   localparam logic [1:0]  K_LED   = 2'd1;
   localparam logic [1:0]  K_SEG   = 2'd2;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst = 1'b1;
   logic [31:0] perip_addr = 32'h0;
   logic        perip_wen = 1'b0;
   logic [1:0]  perip_mask = 2'b00;
   logic [31:0] perip_wdata = 32'h0;
   logic [31:0] perip_rdata;
   logic [23:0] sw = 24'h0;
   logic [23:0] led;
   logic [31:0] seg_data;

   perip_bridge #(
      .DRAM_WORDS (DRAM_WORDS),
      .PRESCALE   (PRESCALE)
   ) dut (
      .cpu_clk     (cpu_clk),
      .cpu_rst     (cpu_rst),
      .perip_addr  (perip_addr),
      .perip_wen   (perip_wen),
      .perip_mask  (perip_mask),
      .perip_wdata (perip_wdata),
      .perip_rdata (perip_rdata),
      .sw          (sw),
      .led         (led),
      .seg_data    (seg_data)
   );

   always #5 cpu_clk = ~cpu_clk;

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] addr;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   task automatic push(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] val);
      exp_t e;
      e.kind = kind;
      e.addr = addr;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] addr,
                        input logic [31:0] got, input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s addr=%h: got %h expected %h at %0t", name, addr, got, want, $time);
      end
   endtask

   // Monitor: compare everything the driver queued for this cycle.
   always @(negedge cpu_clk) begin : monitor
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.kind)
            K_RDATA: check("rdata",    e.addr, perip_rdata,    e.val);
            K_LED:   check("led",      e.addr, {8'h0, led},    e.val);
            default: check("seg_data", e.addr, seg_data,       e.val);
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   logic [7:0]      m_mem [DRAM_BYTES];   // byte-addressed, little-endian
   logic [23:0]     m_led;
   logic [31:0]     m_seg;
   bit              m_run;
   longint unsigned m_run_cycles;         // clock edges spent in RUN since last start
   logic [23:0]     m_sw_new;             // sw as seen at the latest edge
   logic [23:0]     m_sw_old;             // sw as seen one edge earlier (readable)

   function automatic bit in_dram(input logic [31:0] a);
      return (a >= DB) && (a < DB + 32'(DRAM_BYTES));
   endfunction

   task automatic model_reset();
      m_led        = '0;
      m_seg        = '0;
      m_run        = 1'b0;
      m_run_cycles = 0;
      m_sw_new     = '0;
      m_sw_old     = '0;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int unsigned off;
      if (in_dram(a)) begin
         off = (a - DB) & ~32'h3;
         return {m_mem[off+3], m_mem[off+2], m_mem[off+1], m_mem[off]};
      end
      if (a == SW_A)  return {8'h0, m_sw_old};
      if (a == LED_A) return {8'h0, m_led};
      if (a == CNT_A) return 32'(m_run_cycles / PRESCALE);
      if (a == SEG_A) return m_seg;
      return 32'h0;
   endfunction

   // Apply the effect of the coming rising edge.
   task automatic model_commit(input logic [31:0] a, input logic w, input logic [1:0] m,
                               input logic [31:0] d, input logic [23:0] s);
      int unsigned off;
      if (w && a == CNT_A && d == 32'h8000_0000) begin
         m_run        = 1'b1;
         m_run_cycles = 0;
      end else if (w && a == CNT_A && d == 32'hFFFF_FFFF) begin
         m_run = 1'b0;
      end else if (m_run) begin
         m_run_cycles++;
      end
      if (w && a == LED_A) m_led = d[23:0];
      if (w && a == SEG_A) m_seg = d;
      if (w && in_dram(a)) begin
         off = a - DB;
         case (m)
            2'b00: m_mem[off] = d[7:0];
            2'b01: if (off % 2 == 0) begin
                      m_mem[off]   = d[7:0];
                      m_mem[off+1] = d[15:8];
                   end
            2'b10: if (off % 4 == 0) begin
                      for (int b = 0; b < 4; b++) m_mem[off+b] = d[8*b +: 8];
                   end
            default: ;
         endcase
      end
      m_sw_old = m_sw_new;
      m_sw_new = s;
   endtask

   // ------------------------------------------------------------------
   // Driver
   // ------------------------------------------------------------------
   logic [23:0] cur_sw = 24'h0;

   task automatic do_cycle(input logic [31:0] a, input logic w, input logic [1:0] m,
                           input logic [31:0] d, input bit chk);
      @(posedge cpu_clk);
      #1;
      perip_addr  = a;
      perip_wen   = w;
      perip_mask  = m;
      perip_wdata = d;
      sw          = cur_sw;
      if (chk) push(K_RDATA, a, model_read(a));
      push(K_LED, LED_A, {8'h0, m_led});
      push(K_SEG, SEG_A, m_seg);
      model_commit(a, w, m, d, cur_sw);
   endtask

   // Assert reset part-way into a cycle and check outputs clear before the next edge.
   task automatic reset_pulse();
      @(posedge cpu_clk);
      #1;
      perip_addr  = CNT_A;
      perip_wen   = 1'b0;
      perip_mask  = 2'b00;
      perip_wdata = 32'h0;
      #1;
      cpu_rst = 1'b1;
      model_reset();
      push(K_RDATA, CNT_A, 32'h0);
      push(K_LED,   LED_A, 32'h0);
      push(K_SEG,   SEG_A, 32'h0);
      @(posedge cpu_clk);
      #1;
      cpu_rst = 1'b0;
      model_commit(CNT_A, 1'b0, 2'b00, 32'h0, cur_sw);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [31:0] bnd [5];
      logic [31:0] a;
      logic [31:0] d;
      logic        w;
      logic [1:0]  m;
      int          sel;

      bnd[0] = DB + 32'(DRAM_BYTES);
      bnd[1] = DB - 32'd4;
      bnd[2] = DB + 32'(DRAM_BYTES) - 32'd4;
      bnd[3] = 32'h8020_0044;
      bnd[4] = 32'h8020_0004;

      model_reset();
      reset_pulse();

      // Give every RAM word a known value before it is ever read.
      for (int i = 0; i < DRAM_WORDS; i++) begin
         do_cycle(DB + 32'(4 * i), 1'b1, 2'b10, $urandom, 1'b0);
      end

      // Word then byte write into the same word.
      do_cycle(DB + 32'h4, 1'b1, 2'b10, 32'h1234_5678, 1'b0);
      do_cycle(DB + 32'h6, 1'b1, 2'b00, 32'h0000_00AB, 1'b0);
      do_cycle(DB + 32'h4, 1'b0, 2'b00, 32'h0, 1'b1);
      push(K_RDATA, DB + 32'h4, 32'h12AB_5678);

      // Misaligned half dropped, aligned half lands in the upper lane.
      do_cycle(DB, 1'b1, 2'b10, 32'h0, 1'b0);
      do_cycle(DB + 32'h1, 1'b1, 2'b01, 32'h0000_BEEF, 1'b0);
      do_cycle(DB, 1'b0, 2'b00, 32'h0, 1'b1);
      push(K_RDATA, DB, 32'h0);
      do_cycle(DB + 32'h2, 1'b1, 2'b01, 32'h0000_BEEF, 1'b0);
      do_cycle(DB + 32'h3, 1'b1, 2'b10, 32'h5555_5555, 1'b0);  // misaligned word dropped
      do_cycle(DB, 1'b1, 2'b10, 32'h1111_1111, 1'b1);          // same-cycle read sees old word
      push(K_RDATA, DB, 32'hBEEF_0000);
      do_cycle(DB, 1'b1, 2'b11, 32'h2222_2222, 1'b1);          // reserved size dropped
      push(K_RDATA, DB, 32'h1111_1111);
      do_cycle(DB, 1'b0, 2'b00, 32'h0, 1'b1);
      push(K_RDATA, DB, 32'h1111_1111);

      // Counter: start, 12 edges, stop, then hold.
      do_cycle(CNT_A, 1'b1, 2'b10, 32'h8000_0000, 1'b1);
      for (int i = 0; i < 12; i++) do_cycle(CNT_A, 1'b0, 2'b00, 32'h0, 1'b1);
      do_cycle(CNT_A, 1'b1, 2'b10, 32'hFFFF_FFFF, 1'b1);
      push(K_RDATA, CNT_A, 32'd3);
      for (int i = 0; i < 20; i++) begin
         do_cycle(CNT_A, 1'b1, 2'b00, 32'h1234_0000, 1'b1);   // other values ignored
         push(K_RDATA, CNT_A, 32'd3);
      end

      // Switch synchronizer latency.
      do_cycle(SW_A, 1'b0, 2'b00, 32'h0, 1'b1);
      do_cycle(SW_A, 1'b0, 2'b00, 32'h0, 1'b1);
      cur_sw = 24'h00_00A5;
      do_cycle(SW_A, 1'b1, 2'b10, 32'hFFFF_FFFF, 1'b1);        // SW is read-only
      do_cycle(SW_A, 1'b0, 2'b00, 32'h0, 1'b1);
      push(K_RDATA, SW_A, 32'h0);
      do_cycle(SW_A, 1'b0, 2'b00, 32'h0, 1'b1);
      push(K_RDATA, SW_A, 32'h0000_00A5);

      // LED / SEG take the whole word regardless of mask.
      do_cycle(LED_A, 1'b1, 2'b00, 32'hFFFF_FFFF, 1'b0);
      do_cycle(LED_A, 1'b0, 2'b00, 32'h0, 1'b1);
      push(K_RDATA, LED_A, 32'h00FF_FFFF);
      do_cycle(SEG_A, 1'b1, 2'b11, 32'hDEAD_BEEF, 1'b0);
      do_cycle(SEG_A, 1'b0, 2'b00, 32'h0, 1'b1);
      push(K_RDATA, SEG_A, 32'hDEAD_BEEF);
      push(K_SEG,   SEG_A, 32'hDEAD_BEEF);

      // Reset mid-count: outputs clear, counter stays 0 in IDLE, RAM survives.
      do_cycle(CNT_A, 1'b1, 2'b10, 32'h8000_0000, 1'b0);
      for (int i = 0; i < 10; i++) do_cycle(CNT_A, 1'b0, 2'b00, 32'h0, 1'b1);
      reset_pulse();
      for (int i = 0; i < 10; i++) begin
         do_cycle(CNT_A, 1'b0, 2'b00, 32'h0, 1'b1);
         push(K_RDATA, CNT_A, 32'h0);
      end
      do_cycle(DB + 32'h4, 1'b0, 2'b00, 32'h0, 1'b1);
      push(K_RDATA, DB + 32'h4, 32'h12AB_5678);

      // Unmapped address: reads 0, writes change nothing.
      do_cycle(LED_A, 1'b1, 2'b10, 32'h0012_3456, 1'b0);
      do_cycle(UNMAP, 1'b0, 2'b00, 32'h0, 1'b1);
      push(K_RDATA, UNMAP, 32'h0);
      do_cycle(UNMAP, 1'b1, 2'b10, 32'h8000_0000, 1'b1);
      do_cycle(UNMAP, 1'b1, 2'b00, 32'hFFFF_FFFF, 1'b1);
      do_cycle(LED_A, 1'b0, 2'b00, 32'h0, 1'b1);
      push(K_RDATA, LED_A, 32'h0012_3456);
      do_cycle(CNT_A, 1'b0, 2'b00, 32'h0, 1'b1);
      push(K_RDATA, CNT_A, 32'h0);
      do_cycle(DB + 32'h4, 1'b0, 2'b00, 32'h0, 1'b1);
      push(K_RDATA, DB + 32'h4, 32'h12AB_5678);

      // Randomized traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0, 1, 2, 3: a = DB + 32'($urandom_range(0, DRAM_BYTES - 1));
            4:          a = SW_A;
            5:          a = LED_A;
            6:          a = CNT_A;
            7:          a = SEG_A;
            8:          a = $urandom;
            default:    a = bnd[$urandom_range(0, 4)];
         endcase
         d = $urandom;
         if (a == CNT_A) begin
            case ($urandom_range(0, 3))
               0:       d = 32'h8000_0000;
               1:       d = 32'hFFFF_FFFF;
               default: ;
            endcase
         end
         w = 1'($urandom_range(0, 1));
         m = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) cur_sw = 24'($urandom);
         do_cycle(a, w, m, d, 1'b1);
      end

      repeat (2) @(posedge cpu_clk);
      @(negedge cpu_clk);
      #1;
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
